// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types and constants for the spike vote decoder.
//   dec_state_t : decoder FSM states (IDLE, COLLECT, DECIDE, HOLD)
//   CODE_*      : class codes carried on spike_code (0 = no spike, 1..3 = class)
//   NUM_CLASSES : number of votable classes
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_HOLD    = 2'd3
    } dec_state_t;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_C1   = 3'd1;
    localparam logic [2:0] CODE_C2   = 3'd2;
    localparam logic [2:0] CODE_C3   = 3'd3;

    localparam int NUM_CLASSES = 3;

endpackage

// File: rtl/snn_spike_vote_decoder_if.sv
// -----------------------------------------------------------------------------
// snn_spike_vote_decoder_if
// Result handshake between the vote decoder and its downstream consumer.
//   class_valid : result valid, held until accepted          (master -> slave)
//   class_ready : consumer accepts when valid && ready        (slave -> master)
//   class_id    : winning class 1..3, 0 when no votes         (master -> slave)
//   win_count   : vote count of the winner                    (master -> slave)
//   no_spike    : all vote counts were zero                   (master -> slave)
//   margin      : winner count minus runner-up count          (master -> slave)
// Parameter CNT_W must match the decoder's vote counter width.
// -----------------------------------------------------------------------------
interface snn_spike_vote_decoder_if #(
    parameter int CNT_W = 8
) ();

    logic             class_valid;
    logic             class_ready;
    logic [1:0]       class_id;
    logic [CNT_W-1:0] win_count;
    logic             no_spike;
    logic [CNT_W-1:0] margin;

    modport master (
        output class_valid,
        output class_id,
        output win_count,
        output no_spike,
        output margin,
        input  class_ready
    );

    modport slave (
        input  class_valid,
        input  class_id,
        input  win_count,
        input  no_spike,
        input  margin,
        output class_ready
    );

endinterface

// File: rtl/snn_sat_counter.sv
// -----------------------------------------------------------------------------
// snn_sat_counter
// Saturating up-counter used for one class's vote tally.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears the count
//   clr     : synchronous clear (start of a new window)
//   inc     : add one vote; holds at all-ones instead of wrapping
//   q       : current count
// -----------------------------------------------------------------------------
module snn_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] q_r;

    // Vote tally: clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else if (clr) begin
            q_r <= '0;
        end else if (inc && (q_r != CNT_MAX)) begin
            q_r <= q_r + W'(1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/snn_spike_vote_decoder.sv
// -----------------------------------------------------------------------------
// snn_spike_vote_decoder
// Output stage of the 2-layer IF network. Opens a window of WINDOW cycles on
// start, counts one vote per class code (1..3) seen on spike_code, then picks
// the class with the most votes (ties go to the lowest class index) and offers
// it on a valid/ready handshake.
//
// Parameters:
//   WINDOW : samples per decision (1..255)
//   CNT_W  : vote counter width; counters saturate at 2^CNT_W-1
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset; aborts any window in flight
//   start      : 1-cycle window request, honoured only in IDLE
//   spike_code : 0 = none, 1..3 = class, 4..7 = illegal (ignored)
//   busy       : high while collecting and deciding
//   result     : master side of snn_spike_vote_decoder_if
// Configuration:
//   SNN_DECODER_MARGIN_EN : when defined, margin = winner minus runner-up,
//                           registered at decision time; otherwise margin = 0
//                           and no runner-up logic exists.
// -----------------------------------------------------------------------------
module snn_spike_vote_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [2:0]                     spike_code,
    output logic                           busy,
    snn_spike_vote_decoder_if.master       result
);

    localparam int               WIN_W    = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    dec_state_t       state_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic             busy_r;
    logic             class_valid_r;
    logic [1:0]       class_id_r;
    logic [CNT_W-1:0] win_count_r;
    logic             no_spike_r;

    logic                   clr_s;
    logic [NUM_CLASSES-1:0] inc_s;
    logic [CNT_W-1:0]       cnt_s [NUM_CLASSES];
    logic [1:0]             win_idx_s;
    logic [CNT_W-1:0]       win_cnt_s;
    logic                   no_votes_s;
    logic [1:0]             class_id_s;

    // A new window clears all tallies at the moment start is accepted.
    assign clr_s = (state_r == ST_IDLE) && start;

    // Decode the incoming class code into one increment strobe per class.
    always_comb begin
        inc_s = 3'b000;
        if (state_r == ST_COLLECT) begin
            case (spike_code)
                CODE_NONE: inc_s = 3'b000;
                CODE_C1:   inc_s = 3'b001;
                CODE_C2:   inc_s = 3'b010;
                CODE_C3:   inc_s = 3'b100;
                default:   inc_s = 3'b000;
            endcase
        end else begin
            inc_s = 3'b000;
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        snn_sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr_s),
            .inc     (inc_s[g]),
            .q       (cnt_s[g])
        );
    end

    // Winner select. Class 3 needs to beat both others strictly and class 2
    // needs to beat class 1 strictly, so equal counts fall to the lower index.
    always_comb begin
        win_idx_s = 2'd1;
        win_cnt_s = cnt_s[0];
        if ((cnt_s[2] > cnt_s[1]) && (cnt_s[2] > cnt_s[0])) begin
            win_idx_s = 2'd3;
            win_cnt_s = cnt_s[2];
        end else if (cnt_s[1] > cnt_s[0]) begin
            win_idx_s = 2'd2;
            win_cnt_s = cnt_s[1];
        end else begin
            win_idx_s = 2'd1;
            win_cnt_s = cnt_s[0];
        end
        no_votes_s = (cnt_s[0] == '0) && (cnt_s[1] == '0) && (cnt_s[2] == '0);
        class_id_s = no_votes_s ? 2'd0 : win_idx_s;
    end

`ifdef SNN_DECODER_MARGIN_EN
    logic [CNT_W-1:0] second_s;
    logic [CNT_W-1:0] margin_s;
    logic [CNT_W-1:0] margin_r;

    function automatic logic [CNT_W-1:0] max2(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Runner-up is the larger of the two non-winning tallies; a tie with the
    // winner therefore yields a margin of zero.
    always_comb begin
        second_s = '0;
        case (win_idx_s)
            2'd3:    second_s = max2(cnt_s[0], cnt_s[1]);
            2'd2:    second_s = max2(cnt_s[0], cnt_s[2]);
            default: second_s = max2(cnt_s[1], cnt_s[2]);
        endcase
        margin_s = win_cnt_s - second_s;
    end
`endif

    // Decoder FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            win_cnt_r     <= '0;
            busy_r        <= 1'b0;
            class_valid_r <= 1'b0;
            class_id_r    <= 2'd0;
            win_count_r   <= '0;
            no_spike_r    <= 1'b0;
`ifdef SNN_DECODER_MARGIN_EN
            margin_r      <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_COLLECT;
                        win_cnt_r <= '0;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    // The tally counters take this cycle's sample on this edge.
                    if (win_cnt_r == WIN_LAST) begin
                        state_r   <= ST_DECIDE;
                    end else begin
                        win_cnt_r <= win_cnt_r + WIN_W'(1);
                    end
                end
                ST_DECIDE: begin
                    class_id_r    <= class_id_s;
                    win_count_r   <= no_votes_s ? '0 : win_cnt_s;
                    no_spike_r    <= no_votes_s;
`ifdef SNN_DECODER_MARGIN_EN
                    margin_r      <= margin_s;
`endif
                    class_valid_r <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_HOLD;
                end
                ST_HOLD: begin
                    // start is deliberately not looked at here, even on the
                    // handshake cycle; a new window needs a start in IDLE.
                    if (class_valid_r && result.class_ready) begin
                        class_valid_r <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_HOLD;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy_r        <= 1'b0;
                    class_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy               = busy_r;
    assign result.class_valid = class_valid_r;
    assign result.class_id    = class_id_r;
    assign result.win_count   = win_count_r;
    assign result.no_spike    = no_spike_r;
`ifdef SNN_DECODER_MARGIN_EN
    assign result.margin      = margin_r;
`else
    assign result.margin      = '0;
`endif

endmodule

// File: tb/tb_snn_spike_vote_decoder.sv
// -----------------------------------------------------------------------------
// tb_snn_spike_vote_decoder
// Self-checking bench for snn_spike_vote_decoder. Two instances are built:
//   dut_a : WINDOW=16, CNT_W=8 (main behaviour)
//   dut_b : WINDOW=12, CNT_W=3 (counter saturation)
// Expected results come from a tally model over the fed code list.
// Honours SNN_DECODER_MARGIN_EN for the expected margin.
// -----------------------------------------------------------------------------
module tb_snn_spike_vote_decoder;

    localparam int WIN_A = 16;
    localparam int CW_A  = 8;
    localparam int WIN_B = 12;
    localparam int CW_B  = 3;

    logic       clk;
    logic       reset_n;
    logic       sel;
    logic       start_d;
    logic [2:0] code_d;
    logic       ready_d;
    logic       busy_a;
    logic       busy_b;
    logic       start_a;
    logic       start_b;
    logic [2:0] code_a;
    logic [2:0] code_b;

    int checks_cnt;
    int errors_cnt;

    snn_spike_vote_decoder_if #(.CNT_W(CW_A)) ifa ();
    snn_spike_vote_decoder_if #(.CNT_W(CW_B)) ifb ();

    // Route the shared stimulus to the selected instance only.
    assign start_a         = start_d & ~sel;
    assign start_b         = start_d & sel;
    assign code_a          = sel ? 3'd0 : code_d;
    assign code_b          = sel ? code_d : 3'd0;
    assign ifa.class_ready = ready_d & ~sel;
    assign ifb.class_ready = ready_d & sel;

    snn_spike_vote_decoder #(.WINDOW(WIN_A), .CNT_W(CW_A)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_a),
        .spike_code (code_a),
        .busy       (busy_a),
        .result     (ifa)
    );

    snn_spike_vote_decoder #(.WINDOW(WIN_B), .CNT_W(CW_B)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_b),
        .spike_code (code_b),
        .busy       (busy_b),
        .result     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int obs_valid, obs_busy, obs_id, obs_wc, obs_ns, obs_mg;

    // Observed outputs of whichever instance is selected.
    always_comb begin
        if (sel) begin
            obs_valid = int'(ifb.class_valid);
            obs_busy  = int'(busy_b);
            obs_id    = int'(ifb.class_id);
            obs_wc    = int'(ifb.win_count);
            obs_ns    = int'(ifb.no_spike);
            obs_mg    = int'(ifb.margin);
        end else begin
            obs_valid = int'(ifa.class_valid);
            obs_busy  = int'(busy_a);
            obs_id    = int'(ifa.class_id);
            obs_wc    = int'(ifa.win_count);
            obs_ns    = int'(ifa.no_spike);
            obs_mg    = int'(ifa.margin);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: tally legal codes, saturate, rank classes by count.
    function automatic void model(input int codes[$], input int cw,
                                  output int id, output int wc,
                                  output int ns, output int mg);
        int cnt[4];
        int ranked[$];
        int cmax;
        cmax = (1 << cw) - 1;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        foreach (codes[i]) begin
            if (codes[i] >= 1 && codes[i] <= 3) cnt[codes[i]]++;
        end
        for (int c = 1; c <= 3; c++) begin
            if (cnt[c] > cmax) cnt[c] = cmax;
        end
        id = 0;
        wc = 0;
        for (int c = 1; c <= 3; c++) begin
            if (cnt[c] > wc) begin
                wc = cnt[c];
                id = c;
            end
        end
        ns = (wc == 0) ? 1 : 0;
        ranked = '{cnt[1], cnt[2], cnt[3]};
        ranked.rsort();
`ifdef SNN_DECODER_MARGIN_EN
        mg = ranked[0] - ranked[1];
`else
        mg = 0;
`endif
    endfunction

    // Run one window on the selected instance and check the decision.
    task automatic run_window(input string tag, input int codes[$],
                              output int id, output int wc);
        int ns, mg;
        model(codes, sel ? CW_B : CW_A, id, wc, ns, mg);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        check_eq({tag, "_busy"}, obs_busy, 1);
        foreach (codes[i]) begin
            code_d = 3'(codes[i]);
            tick();
        end
        code_d = 3'd0;
        check_eq({tag, "_valid_early"}, obs_valid, 0);
        tick();
        check_eq({tag, "_valid"}, obs_valid, 1);
        check_eq({tag, "_id"}, obs_id, id);
        check_eq({tag, "_wc"}, obs_wc, wc);
        check_eq({tag, "_nospike"}, obs_ns, ns);
        check_eq({tag, "_margin"}, obs_mg, mg);
    endtask

    // Hold the result for a while (optionally pulsing start), then accept it.
    task automatic accept(input string tag, input int hold, input bit pulse,
                          input int id, input int wc);
        ready_d = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start_d = pulse & (i % 2 == 0);
            tick();
            check_eq({tag, "_hold_valid"}, obs_valid, 1);
            check_eq({tag, "_hold_id"}, obs_id, id);
            check_eq({tag, "_hold_wc"}, obs_wc, wc);
        end
        ready_d = 1'b1;
        start_d = pulse;
        tick();
        ready_d = 1'b0;
        start_d = 1'b0;
        check_eq({tag, "_acc_valid"}, obs_valid, 0);
        check_eq({tag, "_acc_busy"}, obs_busy, 0);
        check_eq({tag, "_keep_id"}, obs_id, id);
        tick();
        check_eq({tag, "_idle_busy"}, obs_busy, 0);
    endtask

    function automatic void rand_codes(input int n, output int q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(7, 0)));
    endfunction

    initial begin
        int q[$];
        int id, wc;
        checks_cnt = 0;
        errors_cnt = 0;
        sel     = 1'b0;
        start_d = 1'b0;
        code_d  = 3'd0;
        ready_d = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", obs_valid, 0);
        check_eq("rst_busy", obs_busy, 0);
        check_eq("rst_id", obs_id, 0);
        check_eq("rst_wc", obs_wc, 0);
        check_eq("rst_nospike", obs_ns, 0);
        check_eq("rst_margin", obs_mg, 0);
        check_eq("rst_b_valid", int'(ifb.class_valid), 0);
        reset_n = 1'b1;
        tick();

        // Reference window: class1=7, class2=4, class3=2.
        q = '{1, 1, 2, 3, 1, 0, 1, 2, 1, 2, 1, 3, 2, 1, 0, 0};
        run_window("spec", q, id, wc);
        check_eq("spec_id_const", obs_id, 1);
        check_eq("spec_wc_const", obs_wc, 7);
        accept("spec", 2, 1'b0, id, wc);

        // Tie between class 2 and class 3 at five votes each.
        q = '{2, 3, 2, 3, 0, 2, 3, 5, 2, 3, 1, 2, 3, 0, 4, 7};
        run_window("tie", q, id, wc);
        check_eq("tie_id_const", obs_id, 2);
        accept("tie", 0, 1'b0, id, wc);

        // No legal codes at all.
        q = '{0, 4, 5, 6, 7, 0, 0, 4, 5, 6, 7, 0, 0, 0, 7, 6};
        run_window("zero", q, id, wc);
        check_eq("zero_id_const", obs_id, 0);
        accept("zero", 1, 1'b0, id, wc);

        // Long stall with start pulses that must be ignored.
        rand_codes(WIN_A, q);
        run_window("stall", q, id, wc);
        accept("stall", 10, 1'b1, id, wc);

        // Abort a window mid-way: everything returns to reset values.
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            code_d = 3'd1;
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", obs_busy, 0);
        check_eq("abort_valid", obs_valid, 0);
        check_eq("abort_id", obs_id, 0);
        check_eq("abort_wc", obs_wc, 0);
        tick();
        reset_n = 1'b1;
        code_d  = 3'd1;
        for (int i = 0; i < WIN_A + 4; i++) begin
            tick();
            check_eq("abort_no_valid", obs_valid, 0);
            check_eq("abort_idle", obs_busy, 0);
        end
        code_d = 3'd0;

        // Randomized windows on the wide-counter instance.
        for (int n = 0; n < 8; n++) begin
            rand_codes(WIN_A, q);
            run_window("rand_a", q, id, wc);
            accept("rand_a", int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), id, wc);
        end

        // Narrow-counter instance: saturation and illegal codes.
        sel = 1'b1;
        tick();
        q = {};
        for (int i = 0; i < WIN_B; i++) q.push_back(3);
        run_window("sat", q, id, wc);
        check_eq("sat_wc_const", obs_wc, 7);
        accept("sat", 1, 1'b0, id, wc);

        q = '{3, 5, 3, 6, 3, 7, 3, 5, 3, 6, 3, 7};
        run_window("illegal", q, id, wc);
        check_eq("illegal_wc_const", obs_wc, 6);
        accept("illegal", 0, 1'b0, id, wc);

        for (int n = 0; n < 4; n++) begin
            rand_codes(WIN_B, q);
            run_window("rand_b", q, id, wc);
            accept("rand_b", int'($urandom_range(2, 0)), 1'b0, id, wc);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
